// File: rtl/cdc_xfer_pkg.sv
// Shared types and constants for the cdc_xfer_arbiter source-side CDC request channel.
package cdc_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } xfer_state_e;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_xfer_arbiter_if.sv
// Requester, destination-handshake and status signals of cdc_xfer_arbiter.
// master = the arbiter itself; slave = the surrounding requesters/destination.
interface cdc_xfer_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          xfer_req;
    logic [DATA_WIDTH-1:0]         xfer_data;
    logic [SRC_W-1:0]              xfer_src;
    logic                          xfer_ack;
    logic                          busy;
    logic                          err_clr;
    logic                          timeout_err;

    modport master (
        input  req_valid, req_data, xfer_ack, err_clr,
        output req_ready, xfer_req, xfer_data, xfer_src, busy, timeout_err
    );

    modport slave (
        output req_valid, req_data, xfer_ack, err_clr,
        input  req_ready, xfer_req, xfer_data, xfer_src, busy, timeout_err
    );

endinterface

// File: rtl/cdc_rr_arbiter.sv
// Combinational round-robin arbiter: first valid at or above ptr_i, wrapping to 0.
module cdc_rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        int unsigned     jw;
        logic [IDX_W-1:0] j;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        jw      = 0;
        j       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            jw = int'(ptr_i) + k;
            if (jw >= NUM_REQ) begin
                jw = jw - NUM_REQ;
            end
            j = IDX_W'(jw);
            if (!any_o && valid_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = j;
            end
        end
    end

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Round-robin arbiter in front of a single 4-phase req/ack CDC channel.
// Optional handshake timeout: define CDC_XFER_TIMEOUT_EN.
module cdc_xfer_arbiter
    import cdc_xfer_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    cdc_xfer_arbiter_if.master  bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    xfer_state_e             state_q, state_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q;
    logic                    ack_s;
    logic                    xfer_req_q, xfer_req_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d, data_sel;
    logic [IDX_W-1:0]        src_q, src_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]      grant;
    logic [IDX_W-1:0]        gidx;
    logic                    gany;
    logic [NUM_REQ-1:0]      ready;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    cdc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid_i (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (gany)
    );

    always_comb begin
        data_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == gidx) begin
                data_sel = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef CDC_XFER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_hit, tmo_set;
    logic             err_q, err_d;

    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d    = state_q;
        xfer_req_d = xfer_req_q;
        data_d     = data_q;
        src_d      = src_q;
        ptr_d      = ptr_q;
        ready      = '0;
`ifdef CDC_XFER_TIMEOUT_EN
        tmo_set    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // A still-high synchronized ack belongs to an earlier handshake; hold off.
                if (!ack_s && gany) begin
                    ready      = grant;
                    data_d     = data_sel;
                    src_d      = gidx;
                    xfer_req_d = 1'b1;
                    state_d    = REQ;
                    ptr_d      = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                end
            end
            REQ: begin
                if (ack_s) begin
                    xfer_req_d = 1'b0;
                    state_d    = RELEASE;
                end
`ifdef CDC_XFER_TIMEOUT_EN
                else if (tmo_hit) begin
                    tmo_set    = 1'b1;
                    xfer_req_d = 1'b0;
                    state_d    = RELEASE;
                end
`endif
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end
`ifdef CDC_XFER_TIMEOUT_EN
                else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                xfer_req_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

`ifdef CDC_XFER_TIMEOUT_EN
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_d != state_q || state_q == IDLE) begin
            cnt_d = '0;
        end
        // A new timeout outranks a coincident clear.
        err_d = err_q;
        if (tmo_set) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.timeout_err = err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_sync_q <= '0;
            xfer_req_q <= 1'b0;
            data_q     <= '0;
            src_q      <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.xfer_ack};
            xfer_req_q <= xfer_req_d;
            data_q     <= data_d;
            src_q      <= src_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.xfer_req  = xfer_req_q;
    assign bus.xfer_data = data_q;
    assign bus.xfer_src  = src_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Self-checking bench for cdc_xfer_arbiter with a scoreboard of expected (src, data) per request.
// Timeout scenario runs only when built with CDC_XFER_TIMEOUT_EN.
module tb_cdc_xfer_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [1:0]    src;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0] words [NR];
    logic ack_auto;
    logic ack_force;
    logic ack_model = 1'b0;
    logic req_d1    = 1'b0;
    logic req_prev  = 1'b0;
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;
    int   rises  = 0;

    cdc_xfer_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    cdc_xfer_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.req_data = {words[3], words[2], words[1], words[0]};
    assign bus.xfer_ack = ack_auto ? ack_model : ack_force;

    // Destination model: raises/lowers ack one cycle after it observes req.
    always @(posedge clk) begin
        #1;
        ack_model = req_d1;
        req_d1    = bus.xfer_req;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] src, input logic [DW-1:0] data);
        exp_t e;
        e.src  = src;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic wait_busy_low(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {63'd0, bus.busy}, 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.xfer_req && !req_prev) begin
            rises++;
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_xfer", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_xfer_src", {62'd0, bus.xfer_src}, {62'd0, e.src});
                check_eq("sb_xfer_data", {32'd0, bus.xfer_data}, {32'd0, e.data});
            end
        end
        req_prev = bus.xfer_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        bus.req_valid = '0;
        bus.err_clr   = 1'b0;
        for (int i = 0; i < NR; i++) words[i] = '0;
        ack_auto  = 1'b1;
        ack_force = 1'b0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_xfer_req",  {63'd0, bus.xfer_req}, 64'd0);
        check_eq("rst_xfer_data", {32'd0, bus.xfer_data}, 64'd0);
        check_eq("rst_xfer_src",  {62'd0, bus.xfer_src}, 64'd0);
        check_eq("rst_busy",      {63'd0, bus.busy}, 64'd0);
        check_eq("rst_tmo_err",   {63'd0, bus.timeout_err}, 64'd0);
        check_eq("rst_ready",     {60'd0, bus.req_ready}, 64'd0);
        rst = 1'b0;

        // Single requester: one-cycle ready pulse, req on next edge
        @(negedge clk);
        words[0] = 32'hDEADBEEF;
        bus.req_valid = 4'b0001;
        push_exp(2'd0, 32'hDEADBEEF);
        #1 check_eq("t1_ready", {60'd0, bus.req_ready}, 64'h1);
        @(negedge clk);
        bus.req_valid = '0;
        check_eq("t1_ready_drop", {60'd0, bus.req_ready}, 64'h0);
        check_eq("t1_xfer_req",   {63'd0, bus.xfer_req}, 64'd1);
        check_eq("t1_busy",       {63'd0, bus.busy}, 64'd1);

        // Handshake latency: two sync cycles, then the FSM edge
        n = 0;
        while (!bus.xfer_ack && n < 10) begin @(negedge clk); n++; end
        check_eq("t2_ack_rise", {63'd0, bus.xfer_ack}, 64'd1);
        n = 0;
        @(negedge clk);
        while (bus.xfer_req && n < 10) begin n++; @(negedge clk); end
        check_eq("t2_req_fall_lat", n, 64'd2);
        check_eq("t2_data_hold", {32'd0, bus.xfer_data}, 64'hDEADBEEF);
        n = 0;
        while (bus.xfer_ack && n < 10) begin @(negedge clk); n++; end
        check_eq("t2_ack_fall", {63'd0, bus.xfer_ack}, 64'd0);
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 10) begin n++; @(negedge clk); end
        check_eq("t2_busy_fall_lat", n, 64'd2);

        // Round robin from a fresh pointer: 0,1,2,3,0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) words[i] = 32'h1111_0000 + 32'(i);
        for (int i = 0; i < 5; i++) push_exp(2'(i % NR), 32'h1111_0000 + 32'(i % NR));
        base = rises;
        bus.req_valid = 4'b1111;
        n = 0;
        while (rises < base + 5 && n < 300) begin @(negedge clk); n++; end
        bus.req_valid = '0;
        check_eq("t3_xfer_count", rises - base, 64'd5);
        wait_busy_low("t3_busy_timeout");

        // Stale ack at reset release gates the grant
        ack_auto  = 1'b0;
        ack_force = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        words[0] = 32'hA5A5_0004;
        bus.req_valid = 4'b0001;
        #1 check_eq("t4_gated_0", {60'd0, bus.req_ready}, 64'h0);
        repeat (3) begin
            @(negedge clk);
            check_eq("t4_gated", {60'd0, bus.req_ready}, 64'h0);
            check_eq("t4_idle",  {63'd0, bus.busy}, 64'd0);
        end
        ack_force = 1'b0;
        push_exp(2'd0, 32'hA5A5_0004);
        #1 check_eq("t4_ack_fall_c0", {60'd0, bus.req_ready}, 64'h0);
        @(negedge clk);
        check_eq("t4_ack_fall_c1", {60'd0, bus.req_ready}, 64'h0);
        @(negedge clk);
        check_eq("t4_grant", {60'd0, bus.req_ready}, 64'h1);
        ack_auto = 1'b1;
        @(negedge clk);
        bus.req_valid = '0;
        check_eq("t4_xfer_req", {63'd0, bus.xfer_req}, 64'd1);
        wait_busy_low("t4_busy_timeout");

        // Asynchronous reset while in REQ
        ack_auto  = 1'b0;
        ack_force = 1'b0;
        words[2] = 32'hC0DE_0002;
        bus.req_valid = 4'b0100;
        push_exp(2'd2, 32'hC0DE_0002);
        @(negedge clk);
        bus.req_valid = '0;
        check_eq("t5_in_req", {63'd0, bus.xfer_req}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t5_async_req", {63'd0, bus.xfer_req}, 64'd0);
        check_eq("t5_async_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        words[3] = 32'h0BAD_F00D;
        bus.req_valid = 4'b1000;
        push_exp(2'd3, 32'h0BAD_F00D);
        #1 check_eq("t5_regrant", {60'd0, bus.req_ready}, 64'h8);
        @(negedge clk);
        bus.req_valid = '0;
        ack_auto = 1'b1;
        check_eq("t5_xfer_req", {63'd0, bus.xfer_req}, 64'd1);
        wait_busy_low("t5_busy_timeout");

`ifdef CDC_XFER_TIMEOUT_EN
        // Destination never acks: 16 REQ cycles, then RELEASE and IDLE
        ack_auto  = 1'b0;
        ack_force = 1'b0;
        words[1] = 32'h7777_0001;
        bus.req_valid = 4'b0010;
        push_exp(2'd1, 32'h7777_0001);
        @(negedge clk);
        bus.req_valid = '0;
        n = 0;
        while (bus.xfer_req && n < 40) begin n++; @(negedge clk); end
        check_eq("t6_req_cycles", n, 64'd16);
        check_eq("t6_tmo_set", {63'd0, bus.timeout_err}, 64'd1);
        @(negedge clk);
        check_eq("t6_back_idle", {63'd0, bus.busy}, 64'd0);
        check_eq("t6_tmo_sticky", {63'd0, bus.timeout_err}, 64'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check_eq("t6_tmo_clr", {63'd0, bus.timeout_err}, 64'd0);
        ack_auto = 1'b1;
`endif

        check_eq("end_tmo_err", {63'd0, bus.timeout_err}, 64'd0);
        check_eq("sb_drained", sb_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
